// File: rtl/mantissa_pkg.sv
// mantissa_pkg: constants and FSM state type shared by the mantissa divider and multiplier
//   MANT_W      mantissa width including hidden bit
//   PROD_W      full product width
//   mul_state_t IDLE / RUN / DONE sequencing states
package mantissa_pkg;
    localparam int MANT_W = 7;
    localparam int PROD_W = 2 * MANT_W;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/cla_8bit.sv
// cla_8bit: 8-bit carry-lookahead adder
//   a, b  addends
//   c0    carry in
//   s     sum
//   c8    carry out
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       c0,
    output logic [7:0] s,
    output logic       c8
);
    logic [7:0] g, p;
    logic [8:0] c;
    assign g = a & b;
    assign p = a ^ b;
    // Each nibble resolves its carries from generate/propagate terms; the upper
    // nibble's carry-in comes from the lower nibble's group generate/propagate.
    always_comb begin
        c[0] = c0;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & c[0]);
        c[5] = g[4] | (p[4] & c[4]);
        c[6] = g[5] | (p[5] & g[4]) | (&p[5:4] & c[4]);
        c[7] = g[6] | (p[6] & g[5]) | (&p[6:5] & g[4]) | (&p[6:4] & c[4]);
        c[8] = g[7] | (p[7] & g[6]) | (&p[7:6] & g[5]) | (&p[7:5] & g[4]) | (&p[7:4] & c[4]);
    end
    assign s  = p ^ c[7:0];
    assign c8 = c[8];
endmodule

// File: rtl/mantissa_mul.sv
// mantissa_mul: sequential radix-2 shift-add mantissa multiplier, one bit per cycle
//   clk           rising-edge clock
//   clr_n         asynchronous active-low reset
//   multiplicand  operand A, sampled on the start edge
//   multiplier    operand B, sampled on the start edge
//   ctrl_mul      start request, level-sampled in IDLE and DONE
//   product       A*B, valid while ready, otherwise holds the last result
//   ready         result valid (DONE)
//   busy          iterating (RUN)
//   rounded       normalized, round-to-nearest-even mantissa (MANTISSA_MUL_ROUND_EN only)
//   exp_inc       exponent increment from normalization/rounding (MANTISSA_MUL_ROUND_EN only)
// Define MANTISSA_MUL_ROUND_EN to add the rounded/exp_inc outputs.
module mantissa_mul
    import mantissa_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 ctrl_mul,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ready,
    output logic                 busy
`ifdef MANTISSA_MUL_ROUND_EN
    ,
    output logic [WIDTH-1:0]     rounded,
    output logic                 exp_inc
`endif
);
    localparam int CW = $clog2(WIDTH);

    mul_state_t        state, state_nxt;
    logic [WIDTH:0]    acc_u, addend, sum;
    logic [WIDTH-1:0]  acc_l, mcand;
    logic [CW-1:0]     cnt;
    logic [2*WIDTH:0]  shifted;
    logic              carry, load, step, last;

    assign addend = acc_l[0] ? {1'b0, mcand} : '0;

    cla_8bit u_cla (
        .a  (acc_u),
        .b  (addend),
        .c0 (1'b0),
        .s  (sum),
        .c8 (carry)
    );

    // {carry, sum, L} >> 1; carry is always 0 here, so this equals {sum, L} >> 1.
    assign shifted = {carry, sum, acc_l[WIDTH-1:1]};
    assign last    = cnt == CW'(WIDTH - 1);
    assign ready   = state == DONE;
    assign busy    = state == RUN;

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) state <= IDLE;
        else        state <= state_nxt;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                load      = ctrl_mul;
                state_nxt = ctrl_mul ? RUN : state;
            end
            RUN: begin
                step      = 1'b1;
                state_nxt = last ? DONE : RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            acc_u   <= '0;
            acc_l   <= '0;
            mcand   <= '0;
            cnt     <= '0;
            product <= '0;
        end else if (load) begin
            acc_u <= '0;
            acc_l <= multiplier;
            mcand <= multiplicand;
            cnt   <= '0;
        end else if (step) begin
            {acc_u, acc_l} <= shifted;
            cnt            <= cnt + 1'b1;
            if (last) product <= shifted[2*WIDTH-1:0];
        end

`ifdef MANTISSA_MUL_ROUND_EN
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   norm;
    logic [WIDTH:0]     inc;
    logic               hi, guard, sticky;

    assign p      = shifted[2*WIDTH-1:0];
    assign hi     = p[2*WIDTH-1];
    assign norm   = hi ? p[2*WIDTH-1:WIDTH] : p[2*WIDTH-2:WIDTH-1];
    assign guard  = hi ? p[WIDTH-1] : p[WIDTH-2];
    assign sticky = hi ? |p[WIDTH-2:0] : |p[WIDTH-3:0];
    // Ties go to even: round up on a set guard only if sticky or the lsb is set.
    assign inc    = {1'b0, norm} + (WIDTH + 1)'(guard & (sticky | norm[0]));

    always_ff @(posedge clk or negedge clr_n)
        if (!clr_n) begin
            rounded <= '0;
            exp_inc <= 1'b0;
        end else if (step && last) begin
            // On carry-out inc is 1000..0, so its top WIDTH bits give 100..0.
            rounded <= inc[WIDTH] ? inc[WIDTH:1] : inc[WIDTH-1:0];
            exp_inc <= hi | inc[WIDTH];
        end
`else
`endif
endmodule

// File: tb/tb_mantissa_mul.sv
// tb_mantissa_mul: directed self-checking bench for mantissa_mul
module tb_mantissa_mul;
    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic [6:0]  multiplicand = '0, multiplier = '0;
    logic        ctrl_mul = 1'b0;
    logic [13:0] product;
    logic        ready, busy;
`ifdef MANTISSA_MUL_ROUND_EN
    logic [6:0]  rounded;
    logic        exp_inc;
`endif
    int n_cmp = 0, n_bad = 0;

    mantissa_mul dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .ctrl_mul     (ctrl_mul),
        .product      (product),
        .ready        (ready),
        .busy         (busy)
`ifdef MANTISSA_MUL_ROUND_EN
        ,
        .rounded      (rounded),
        .exp_inc      (exp_inc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [6:0] a, input logic [6:0] b);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        ctrl_mul     = 1'b1;
        @(posedge clk);
        #1 ctrl_mul = 1'b0;
    endtask

    // Counts edges after the load edge until ready (bounded) and the busy samples seen.
    task automatic wait_done(input string tag, input int lat_exp);
        int n = 0, nb = 0;
        while (!ready && n < 20) begin
            if (busy) nb++;
            @(posedge clk);
            #1 n++;
        end
        chk({tag, " latency"}, n, lat_exp);
        chk({tag, " busy cycles"}, nb, lat_exp);
    endtask

    task automatic run_op(input string tag, input logic [6:0] a, input logic [6:0] b,
                          input logic [13:0] exp_p, input logic [6:0] exp_r, input logic exp_e);
        start(a, b);
        chk({tag, " busy after load"}, {ready, busy}, 2'b01);
        wait_done(tag, 7);
        chk({tag, " product"}, product, exp_p);
`ifdef MANTISSA_MUL_ROUND_EN
        chk({tag, " rounded"}, rounded, exp_r);
        chk({tag, " exp_inc"}, exp_inc, exp_e);
`else
        if (exp_r === 7'h7F && exp_e === 1'b1) $display("note: %s not rounded", tag);
`endif
        repeat (3) @(posedge clk);
        #1 chk({tag, " held"}, {ready, busy, product}, {2'b10, exp_p});
    endtask

    initial begin
        #1 clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset outputs", {ready, busy, product}, 16'h0);
`ifdef MANTISSA_MUL_ROUND_EN
        chk("reset round", {exp_inc, rounded}, 8'h0);
`endif
        @(negedge clk) clr_n = 1'b1;

        run_op("40x40", 7'h40, 7'h40, 14'h1000, 7'h40, 1'b0);
        run_op("7Fx7F", 7'h7F, 7'h7F, 14'h3F01, 7'h7E, 1'b1);
        run_op("00x55", 7'h00, 7'h55, 14'h0000, 7'h00, 1'b0);
        run_op("01x01", 7'h01, 7'h01, 14'h0001, 7'h00, 1'b0);

        // Previous result must hold while the next operation iterates.
        start(7'h7F, 7'h7F);
        chk("hold during run", product, 14'h0001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        multiplicand = 7'h01;
        multiplier   = 7'h01;
        ctrl_mul     = 1'b1;
        @(posedge clk);
        #1 ctrl_mul = 1'b0;
        wait_done("ignore start", 4);
        chk("ignore start product", product, 14'h3F01);

        // Asynchronous clear in the middle of iteration 3.
        start(7'h7F, 7'h7F);
        repeat (3) @(posedge clk);
        #2 clr_n = 1'b0;
        #1 chk("async clear", {ready, busy, product}, 16'h0);
        @(negedge clk) clr_n = 1'b1;
        run_op("60x50", 7'h60, 7'h50, 14'h1E00, 7'h78, 1'b0);

        // Continuous start: ready pulses one cycle in every eight.
        @(negedge clk);
        multiplicand = 7'h41;
        multiplier   = 7'h43;
        ctrl_mul     = 1'b1;
        @(posedge clk);
        begin
            int pulses = 0;
            for (int i = 1; i <= 24; i++) begin
                @(posedge clk);
                #1 if (ready) begin
                    pulses++;
                    chk("b2b pulse phase", i % 8, 7);
                    chk("b2b product", product, 14'h1103);
                end
            end
            chk("b2b pulse count", pulses, 3);
        end
        ctrl_mul = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
